// File: rtl/slot_alloc_pkg.sv
// Shared types and helpers for the slot allocator: FSM state enum, slot limits,
// and index-to-one-hot conversion.
package slot_alloc_pkg;

    localparam int MAX_SLOTS = 10;
    localparam int MAX_IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        PARTIAL,
        FULL
    } state_e;

    function automatic logic [MAX_SLOTS-1:0] idxToOneHot(input logic [MAX_IDX_W-1:0] idx);
        idxToOneHot = '0;
        for (int i = 0; i < MAX_SLOTS; i++) begin
            if (idx == MAX_IDX_W'(i)) begin
                idxToOneHot[i] = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/slot_alloc_lsz.sv
// Least-significant-zero encoder: finds the lowest free slot in the busy bitmap.
// An all-ones input yields zero outputs; the caller never accepts in that case.
module slot_alloc_lsz
    import slot_alloc_pkg::*;
#(
    parameter int BITWIDTH    = 4,
    parameter int LOGBITWIDTH = $clog2(BITWIDTH)
) (
    input  logic [BITWIDTH-1:0]    iGrey,
    output logic [BITWIDTH-1:0]    oOneHot,
    output logic [LOGBITWIDTH-1:0] oIdx
);

    // Scan from the top down so the lowest zero bit is the last one written.
    always_comb begin
        oOneHot = '0;
        oIdx    = '0;
        for (int i = BITWIDTH - 1; i >= 0; i--) begin
            if (!iGrey[i]) begin
                oOneHot    = '0;
                oOneHot[i] = 1'b1;
                oIdx       = LOGBITWIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/slot_alloc.sv
// Slot allocator: grants the lowest free slot through a valid/ready handshake and
// accepts releases. Optional macro SLOT_ALLOC_REL_BYPASS_EN lets a release feed a grant while full.
module slot_alloc
    import slot_alloc_pkg::*;
#(
    parameter int BITWIDTH    = 4,
    parameter int LOGBITWIDTH = $clog2(BITWIDTH)
) (
    input  logic                   iClk,
    input  logic                   iRstN,
    input  logic                   iReqValid,
    output logic                   oReqReady,
    output logic                   oGntValid,
    output logic [LOGBITWIDTH-1:0] oGntIdx,
    output logic [BITWIDTH-1:0]    oGntOneHot,
    input  logic                   iRelValid,
    input  logic [LOGBITWIDTH-1:0] iRelIdx,
    output logic [BITWIDTH-1:0]    oBusy,
    output logic                   oFull,
    output logic                   oEmpty,
    output logic                   oErr
);

    logic [BITWIDTH-1:0]    busy_q, busy_d;
    logic [BITWIDTH-1:0]    gntOneHot_q, gntOneHot_d;
    logic [LOGBITWIDTH-1:0] gntIdx_q, gntIdx_d;
    logic                   gntValid_q, gntValid_d;
    logic                   err_q, err_d;
    state_e                 state_q, state_d;

    logic [BITWIDTH-1:0]    freeOneHot;
    logic [LOGBITWIDTH-1:0] freeIdx;
    logic [BITWIDTH-1:0]    relHit;
    logic                   relLegal;
    logic                   bypass;
    logic                   accept;

    slot_alloc_lsz #(
        .BITWIDTH   (BITWIDTH),
        .LOGBITWIDTH(LOGBITWIDTH)
    ) uLsz (
        .iGrey  (busy_q),
        .oOneHot(freeOneHot),
        .oIdx   (freeIdx)
    );

    // An out-of-range index decodes to a bit above BITWIDTH, which truncation drops.
    assign relHit   = BITWIDTH'(idxToOneHot(MAX_IDX_W'(iRelIdx))) & busy_q;
    assign relLegal = iRelValid & (|relHit);

`ifdef SLOT_ALLOC_REL_BYPASS_EN
    assign bypass = (state_q == FULL) & relLegal;
`else
    assign bypass = 1'b0;
`endif

    assign oReqReady = (state_q != FULL) | bypass;
    assign accept    = iReqValid & oReqReady;

    // Release applies first; a bypass grant re-sets the same bit so busy stays full.
    always_comb begin
        busy_d      = busy_q;
        gntIdx_d    = gntIdx_q;
        gntOneHot_d = gntOneHot_q;
        gntValid_d  = accept;
        err_d       = err_q | (iRelValid & ~relLegal);
        if (relLegal) begin
            busy_d = busy_d & ~relHit;
        end
        if (accept) begin
            if (bypass) begin
                gntIdx_d    = iRelIdx;
                gntOneHot_d = relHit;
                busy_d      = busy_d | relHit;
            end else begin
                gntIdx_d    = freeIdx;
                gntOneHot_d = freeOneHot;
                busy_d      = busy_d | freeOneHot;
            end
        end
        if (busy_d == '0) begin
            state_d = IDLE;
        end else if (&busy_d) begin
            state_d = FULL;
        end else begin
            state_d = PARTIAL;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            busy_q      <= '0;
            gntIdx_q    <= '0;
            gntOneHot_q <= '0;
            gntValid_q  <= 1'b0;
            err_q       <= 1'b0;
            state_q     <= IDLE;
        end else begin
            busy_q      <= busy_d;
            gntIdx_q    <= gntIdx_d;
            gntOneHot_q <= gntOneHot_d;
            gntValid_q  <= gntValid_d;
            err_q       <= err_d;
            state_q     <= state_d;
        end
    end

    assign oBusy      = busy_q;
    assign oGntValid  = gntValid_q;
    assign oGntIdx    = gntIdx_q;
    assign oGntOneHot = gntOneHot_q;
    assign oErr       = err_q;
    assign oFull      = (state_q == FULL);
    assign oEmpty     = (state_q == IDLE);

endmodule

// File: doc/slot_alloc.md
Name: slot_alloc

Overview:
- Allocator/scheduler for a pool of BITWIDTH identical unary compute slots (e.g. butterfly lanes).
- Keeps a busy bitmap and grants the lowest-index free slot to a requester through a valid/ready handshake.
- Accepts slot releases from the datapath.
- Sits between the butterfly stage sequencer (requester) and the lane array. It uses least-significant-zero search on the busy bitmap to choose the slot.

Parameters:
- BITWIDTH, 4, number of slots; legal range 2..10.
- LOGBITWIDTH, $clog2(BITWIDTH), width of a slot index.

Ports:
- iClk  input  1  clock, rising edge.
- iRstN  input  1  asynchronous active-low reset.
- iReqValid  input  1  requester wants a slot.
- oReqReady  output  1  a slot can be granted this cycle.
- oGntValid  output  1  one-cycle pulse; grant outputs valid.
- oGntIdx  output  LOGBITWIDTH  granted slot index.
- oGntOneHot  output  BITWIDTH  granted slot, one-hot.
- iRelValid  input  1  release request.
- iRelIdx  input  LOGBITWIDTH  slot being released.
- oBusy  output  BITWIDTH  current busy bitmap, registered.
- oFull  output  1  all slots busy.
- oEmpty  output  1  no slot busy.
- oErr  output  1  sticky illegal-release flag.

Behaviour:
- Reset (async, iRstN=0): busy=0, oGntValid=0, oGntIdx=0, oGntOneHot=0, oErr=0, FSM=IDLE. Therefore oEmpty=1, oFull=0, oReqReady=1.
- Reset asserted mid-operation discards all outstanding allocations immediately. No grant pulse follows reset release.
- Handshake:
  - oReqReady = ~oFull, combinational from registered busy (see the optional feature for the one exception).
  - A request is accepted when iReqValid & oReqReady at a rising edge.
- Slot selection: the lowest-index zero bit of busy, evaluated on the pre-edge bitmap.
- Grant latency:
  - Accept at edge N sets busy[idx] at edge N.
  - oGntValid=1 with oGntIdx/oGntOneHot for exactly the cycle after edge N.
  - Otherwise oGntValid=0; oGntIdx/oGntOneHot hold their last value.
- Back-to-back accepts are legal every cycle; throughput is 1 grant/cycle.
- Release:
  - On iRelValid, if busy[iRelIdx]=1, the bit clears at the edge.
  - If busy[iRelIdx]=0, or iRelIdx>=BITWIDTH, nothing changes and oErr sets. oErr clears only on reset.
- Simultaneous accept and release in one cycle:
  - Both apply; allocation uses the pre-release bitmap.
  - The released slot is not re-granted that cycle (except with the bypass feature).
  - The granted index can never equal iRelIdx, since it was free.
- FSM states, derived from next busy:
  - IDLE (busy==0), PARTIAL, FULL (busy all ones).
  - Transitions are evaluated from busy_next each edge: IDLE<->PARTIAL<->FULL.
  - IDLE->FULL directly is possible only when BITWIDTH... (N/A, since one grant per cycle); FULL->IDLE directly only when BITWIDTH... (N/A).
  - oEmpty = (state==IDLE); oFull = (state==FULL).
- iReqValid while full: not accepted; the requester holds iReqValid (no drop, no error).
- Index width: oGntIdx is zero-extended from the priority encoder. The all-ones bitmap never reaches the encoder output because ready gates it.

Optional Feature:
- Macro SLOT_ALLOC_REL_BYPASS_EN.
- When defined:
  - In FULL with a legal iRelValid, oReqReady=1.
  - An accepted request is granted iRelIdx directly; busy stays full and that bit stays set.
  - oGntValid pulses next cycle with oGntIdx=iRelIdx.
- When undefined: oReqReady=0 in FULL regardless of release; behaviour is as above.

Decomposition:
- Shared package slot_alloc_pkg holds:
  - the FSM state enum {IDLE, PARTIAL, FULL};
  - the MAX_SLOTS=10 constant;
  - the index-to-one-hot conversion function.
- One sub-module: the existing lsz LS-zero encoder, instantiated with BITWIDTH. It takes iGrey=busy and yields the one-hot and index of the first free slot.
- All state (busy, grant regs, err, FSM) lives in slot_alloc.

Test Plan (BITWIDTH=4):
- Reset, then iReqValid=1 for 4 cycles -> grants idx 0,1,2,3 on consecutive cycles; busy=4'b1111; oFull=1; oReqReady=0.
- From full, release idx 2 with no request -> busy=4'b1011. Next request grants idx 2 (oGntOneHot=4'b0100).
- busy=4'b0011, same cycle request + release idx 0 -> grant idx 2 (not 0); busy next=4'b0110.
- Release idx 3 while busy=4'b0001 -> busy unchanged; oErr=1 and stays 1 until reset.
- busy=4'b1111, assert iRstN=0 mid-request -> busy=0, oGntValid=0 immediately; oEmpty=1 after release.
- With SLOT_ALLOC_REL_BYPASS_EN: busy=4'b1111, request + release idx 1 -> accepted, oGntIdx=1 next cycle, busy stays 4'b1111. Without the macro: not accepted, busy=4'b1101.
